// File: rtl/spi_cmd_rx_pkg.sv
// Shared constants and types for the SPI command receiver slice.
package spi_cmd_rx_pkg;

  // {CPOL, CPHA}: the receiver only supports mode 0.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam int DEFAULT_FIFO_DEPTH  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int BYTE_W              = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_cmd_rx_byte_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever the FIFO is non-empty.
// A pop on an empty FIFO is ignored; a push while full only lands when a pop
// in the same cycle makes room.
module byte_fifo
  import spi_cmd_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  // Head is forced to zero when empty so the output has a defined reset value
  // without having to clear the storage array.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers (power-of-two depth wraps naturally) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave front end: MOSI bytes land in a show-ahead FIFO for the
// command controller, and the controller's status byte is returned on MISO.
// All SPI pins are oversampled in the clk domain (needs f_clk >= 8*f_sck).
module spi_cmd_rx
  import spi_cmd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          next,
  input  logic [7:0]                    tx_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam logic SCK_IDLE_LVL = SPI_MODE0[1];

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_n_prev_q, cs_n_prev_d;

  logic sck_s, cs_n_s, mosi_s;
  logic sck_lead, sck_trail;
  logic cs_fall, cs_rise;

  spi_state_e state_q, state_d;
  logic [2:0] bit_ctr_q, bit_ctr_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;
  logic       push_q, push_d;
  logic [7:0] push_data_q, push_data_d;
  logic       overflow_q, overflow_d;

  logic fifo_full;
  logic fifo_empty;

  // Shift each pin into its synchroniser chain; the extra flop holds the previous sample.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
    cs_n_prev_d = cs_n_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser registers. cs_n resets to the asserted level so that a frame
  // already in progress when reset lifts is never mistaken for a new start:
  // cs_n must be seen high before a falling edge can be detected.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_n_sync_q <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_n_sync_q <= cs_n_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_lead  = (sck_s ^ SCK_IDLE_LVL) & ~(sck_prev_q ^ SCK_IDLE_LVL);
  assign sck_trail = ~(sck_s ^ SCK_IDLE_LVL) & (sck_prev_q ^ SCK_IDLE_LVL);
  assign cs_fall   = cs_n_prev_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_prev_q & cs_n_s;

  // FSM state register and the shift/counter datapath it controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_ctr_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_ctr_q   <= bit_ctr_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state: frame on cs_n, sample MOSI on the leading sck edge, advance MISO on the trailing edge.
  // tx_shift holds the bits still to be sent after the one currently on miso.
  always_comb begin
    state_d     = state_q;
    bit_ctr_d   = bit_ctr_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_shift_d = tx_byte[6:0];
          miso_d     = tx_byte[7];
          bit_ctr_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // A partial byte is simply abandoned; only full bytes are pushed.
          miso_d    = 1'b0;
          bit_ctr_d = '0;
          state_d   = IDLE;
        end else if (sck_lead) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_ctr_d  = bit_ctr_q + 1'b1;
          if (bit_ctr_q == 3'd7) begin
            push_d      = 1'b1;
            push_data_d = {rx_shift_q, mosi_s};
          end
        end else if (sck_trail) begin
          if (bit_ctr_q != '0) begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
          end else begin
            // Byte boundary: pick up whatever status the controller shows now.
            miso_d     = tx_byte[7];
            tx_shift_d = tx_byte[6:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overflow: a push found the FIFO full and no pop freed a slot.
  always_comb begin
    overflow_d = overflow_q | (push_q & fifo_full & ~next);
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (next),
    .head      (out_byte),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign miso      = miso_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Bench for spi_cmd_rx: an SPI master task drives frames and predicts the
// received bytes into a queue; a monitor pops the DUT FIFO and compares.
module tb_spi_cmd_rx;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int HALF  = 8;   // f_sck = f_clk/16
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          next;
  logic [7:0]    tx_byte;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  spi_cmd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .next       (next),
    .tx_byte    (tx_byte),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [7:0] exp_q[$];
  bit         ovf_exp   = 1'b0;
  bit         pop_en    = 1'b0;
  int         force_cyc = -1;
  logic [7:0] rxv [0:31];
  logic [7:0] txv [0:32];

  bit lat_arm  = 1'b0;
  bit lat_seen = 1'b0;
  int lat_cyc  = 0;
  int last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
  endtask

  // SPI mode-0 master. Sends nbytes full bytes plus tail extra bits from rxv,
  // checks MISO against txv, optionally pulses reset after bit rst_bit and
  // schedules a controller pop in the same cycle as the push of byte pop_byte.
  task automatic spi_xfer(input int nbytes, input int tail, input int rst_bit, input int pop_byte);
    int         nbits;
    logic [7:0] cap;
    bit         dead;
    nbits = nbytes * 8 + tail;
    cap   = 8'h00;
    dead  = 1'b0;
    tx_byte = txv[0];
    mosi    = rxv[0][7];
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      int idx;
      int bi;
      idx  = b / 8;
      bi   = 7 - (b % 8);
      mosi = rxv[idx][bi];
      repeat (HALF) @(negedge clk);
      cap = {cap[6:0], miso};
      sck = 1'b1;
      if ((b % 8) == 7 && !dead) begin
        if (pop_byte == idx) force_cyc = cyc + SYNC + 1;
        if (exp_q.size() < DEPTH || pop_byte == idx) exp_q.push_back(rxv[idx]);
        else ovf_exp = 1'b1;
        if (lat_arm) last_rise_cyc = cyc;
        check("miso_byte", cap, txv[idx]);
      end
      if ((b % 8) == 3) tx_byte = txv[idx + 1];
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      if (b == rst_bit) begin
        do_reset(3);
        dead = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic drain(input string name);
    pop_en = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_count"}, fifo_count, 0);
    check({name, "_valid"}, out_valid, 1'b0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      rxv[i] = 8'($urandom);
      txv[i] = 8'($urandom);
    end
    txv[n] = 8'($urandom);
  endtask

  // Monitor / consumer: pops with one idle cycle between pops and checks each popped byte.
  bit popped_last = 1'b0;
  initial begin
    next = 1'b0;
    forever begin
      bit         do_pop;
      logic [7:0] e;
      @(negedge clk);
      if (popped_last && exp_q.size() == 0) check("valid_after_pop", out_valid, 1'b0);
      popped_last = 1'b0;
      do_pop = !reset && out_valid && ((pop_en && next == 1'b0) || cyc == force_cyc);
      if (do_pop) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: actual=%0h required=none", out_byte);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", out_byte, e);
        end
        next = 1'b1;
        popped_last = 1'b1;
      end else if (pop_en && !reset && !out_valid && $urandom_range(0, 3) == 0) begin
        next = 1'b1;
      end else begin
        next = 1'b0;
      end
    end
  end

  // Records the first cycle out_valid rises while latency measurement is armed.
  initial begin
    forever begin
      @(negedge clk);
      if (lat_arm && !lat_seen && out_valid) begin
        lat_seen = 1'b1;
        lat_cyc  = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    cs_n    = 1'b0;
    sck     = 1'b0;
    mosi    = 1'b0;
    tx_byte = 8'h5A;

    // Reset with cs_n low and sck toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sck = ~sck;
      check("rst_miso", miso, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 1'b0);
    end
    reset = 1'b0;
    sck   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sck = ~sck;
    end
    repeat (8) @(negedge clk);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_miso", miso, 1'b0);
    cs_n = 1'b1;
    sck  = 1'b0;
    repeat (2 * HALF) @(negedge clk);

    // 0xA5 with latency measurement, then a single pop.
    pop_en = 1'b0;
    rxv[0] = 8'hA5; txv[0] = 8'h81; txv[1] = 8'h00;
    lat_arm = 1'b1; lat_seen = 1'b0;
    spi_xfer(1, 0, -1, -1);
    check("lat_within", (lat_seen && (lat_cyc - last_rise_cyc) <= SYNC + 3), 1'b1);
    lat_arm = 1'b0;
    check("a5_head", out_byte, 8'hA5);
    check("a5_count", fifo_count, 1);
    drain("a5");

    // Status byte changes mid-byte: MISO returns 0x3C then 0xC3.
    rxv[0] = 8'h11; rxv[1] = 8'h22;
    txv[0] = 8'h3C; txv[1] = 8'hC3; txv[2] = 8'h00;
    spi_xfer(2, 0, -1, -1);
    drain("tx2");

    // Aborted 5-bit frame then 0x12.
    pop_en = 1'b0;
    fill_random(2);
    spi_xfer(0, 5, -1, -1);
    rxv[0] = 8'h12;
    spi_xfer(1, 0, -1, -1);
    check("abort_count", fifo_count, 1);
    check("abort_head", out_byte, 8'h12);
    drain("abort");

    // 17 bytes, no pops: 17th dropped, overflow sticky until reset.
    pop_en = 1'b0;
    fill_random(17);
    spi_xfer(17, 0, -1, -1);
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_flag", overflow, ovf_exp);
    drain("ovf");
    check("ovf_sticky", overflow, ovf_exp);
    do_reset(2);
    @(negedge clk);
    check("ovf_cleared", overflow, ovf_exp);

    // 17 bytes with a pop in the same cycle as the 17th push.
    pop_en = 1'b0;
    fill_random(17);
    spi_xfer(17, 0, -1, 16);
    check("pp_count", fifo_count, DEPTH);
    check("pp_flag", overflow, ovf_exp);
    drain("pp");

    // Reset after 3 bits, cs_n stays low through the rest of the frame.
    pop_en = 1'b0;
    fill_random(1);
    spi_xfer(1, 0, 2, -1);
    repeat (8) @(negedge clk);
    check("midrst_count", fifo_count, 0);
    check("midrst_valid", out_valid, 1'b0);
    rxv[0] = 8'h7E; txv[0] = 8'hE7; txv[1] = 8'h00;
    spi_xfer(1, 0, -1, -1);
    check("midrst_head", out_byte, 8'h7E);
    drain("midrst");

    // Randomised frames with a live consumer, including aborted tails.
    pop_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int nb;
      int tl;
      nb = $urandom_range(1, 4);
      tl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      fill_random(nb + 1);
      spi_xfer(nb, tl, -1, -1);
    end
    drain("rand");
    check("rand_ovf", overflow, ovf_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
